// File: rtl/blram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
package blram_pkg;

    // Same-port read-during-write behaviour
    typedef enum logic {READ_FIRST, WRITE_FIRST} rdw_mode_t;

    // Post-reset clear engine states
    typedef enum logic [1:0] {IDLE, CLEAR, READY} clr_state_t;

    // One byte lane of a byte-enable merge: new byte where enabled, else old byte
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/blram_dp_if.sv
// Per-port access bus of the dual-port RAM; master drives requests, slave (the RAM) returns data.
interface blram_dp_if
    import blram_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic                  en;
    logic [DATA_W/8-1:0]   we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;
    logic                  vld;

    modport master (output en, we, addr, din, input dout, vld);
    modport slave  (input en, we, addr, din, output dout, vld);
endinterface

// File: rtl/blram_dp_port.sv
// One RAM port: accept, range check, read-during-write select and the L-stage read pipeline.
module blram_port
    import blram_pkg::*;
#(
    parameter int        ADDR_W   = 14,
    parameter int        DEPTH    = 1024,
    parameter int        DATA_W   = 32,
    parameter int        OUT_REG  = 0,
    parameter rdw_mode_t RDW_MODE = READ_FIRST,
    parameter int        IDX_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                busy,
    blram_dp_if.slave           bus,
    input  logic [DATA_W-1:0]   rdata,  // array word at idx before this edge's writes
    output logic [IDX_W-1:0]    idx,
    output logic [DATA_W/8-1:0] wbe,    // qualified byte enables, zero unless an in-range write
    output logic                oor     // accepted access with an out-of-range address
);
    localparam int NB = DATA_W / 8;
    localparam int L  = 1 + OUT_REG;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic                   acc;
    logic                   in_rng;
    logic [DATA_W-1:0]      rd_word;
    logic [L:1]             vld_pipe_q, vld_pipe_d;
    logic [L:1][DATA_W-1:0] dat_pipe_q, dat_pipe_d;

    // Accept and range check; out-of-range addresses are never wrapped onto the array
    always_comb begin
        acc    = bus.en && !busy && !rst;
        in_rng = ({1'b0, bus.addr} < DEPTH_C);
        idx    = in_rng ? bus.addr[IDX_W-1:0] : '0;
        wbe    = (acc && in_rng) ? bus.we : '0;
        oor    = acc && !in_rng;
    end

    // Read word: zero when out of range; WRITE_FIRST folds in this port's own bytes only
    always_comb begin
        rd_word = rdata;
        if (!in_rng) begin
            rd_word = '0;
        end else if (RDW_MODE == WRITE_FIRST) begin
            for (int i = 0; i < NB; i++)
                rd_word[8*i +: 8] = byte_merge(rdata[8*i +: 8], bus.din[8*i +: 8], wbe[i]);
        end
    end

    // Valid shifts every cycle; data in each stage only moves when its valid does
    always_comb begin
        vld_pipe_d[1] = acc;
        dat_pipe_d[1] = acc ? rd_word : dat_pipe_q[1];
        for (int k = 2; k <= L; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            dat_pipe_d[k] = vld_pipe_q[k-1] ? dat_pipe_q[k-1] : dat_pipe_q[k];
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
        end
    end

    assign bus.dout = dat_pipe_q[L];
    assign bus.vld  = vld_pipe_q[L];

endmodule

// File: rtl/blram_dp.sv
// True dual-port block RAM with byte enables, cross-port collision handling and a zero-fill engine.
module blram_dp
    import blram_pkg::*;
#(
    parameter int        ADDR_W         = 14,
    parameter int        DEPTH          = 1024,
    parameter int        DATA_W         = 32,
    parameter int        OUT_REG        = 0,
    parameter rdw_mode_t RDW_MODE       = READ_FIRST,
    parameter int        CLEAR_ON_RESET = 0
) (
    input  logic      clk,
    input  logic      rst,
    blram_dp_if.slave a_if,
    blram_dp_if.slave b_if,
    output logic      busy,
    output logic      err
);
    localparam int NB    = DATA_W / 8;
    localparam int L     = 1 + OUT_REG;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    clr_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             clr_we;

    logic [IDX_W-1:0] a_idx, b_idx;
    logic [NB-1:0]    a_wbe, b_wbe;
    logic             a_oor, b_oor, coll;
    logic [L:1]       err_pipe_q, err_pipe_d;

    blram_port #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W),
        .OUT_REG(OUT_REG), .RDW_MODE(RDW_MODE), .IDX_W(IDX_W)
    ) u_port_a (
        .clk(clk), .rst(rst), .busy(busy), .bus(a_if),
        .rdata(mem_q[a_idx]), .idx(a_idx), .wbe(a_wbe), .oor(a_oor)
    );

    blram_port #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W),
        .OUT_REG(OUT_REG), .RDW_MODE(RDW_MODE), .IDX_W(IDX_W)
    ) u_port_b (
        .clk(clk), .rst(rst), .busy(busy), .bus(b_if),
        .rdata(mem_q[b_idx]), .idx(b_idx), .wbe(b_wbe), .oor(b_oor)
    );

    // Clear FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear FSM next state: one word per cycle, leave after the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    // Clear FSM outputs; no fill write in a reset cycle so reset never touches contents
    always_comb begin
        busy   = (state_q != READY);
        clr_we = (state_q == CLEAR) && !rst;
    end

    // Error sources: either range violation or both ports writing the same word
    always_comb begin
        coll          = (|a_wbe) && (|b_wbe) && (a_idx == b_idx);
        err_pipe_d[1] = a_oor || b_oor || coll;
        for (int k = 2; k <= L; k++)
            err_pipe_d[k] = err_pipe_q[k-1];
    end

    // Error delayed to line up with the read valids
    always_ff @(posedge clk) begin
        if (rst) err_pipe_q <= '0;
        else     err_pipe_q <= err_pipe_d;
    end

    assign err = err_pipe_q[L];

    // Array write: fill, then B, then A last so A owns bytes both ports enable
    always_ff @(posedge clk) begin
        if (clr_we) mem_q[cnt_q] <= '0;
        for (int i = 0; i < NB; i++) begin
            if (b_wbe[i]) mem_q[b_idx][8*i +: 8] <= b_if.din[8*i +: 8];
            if (a_wbe[i]) mem_q[a_idx][8*i +: 8] <= a_if.din[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_blram_dp.sv
// Directed bench: dut0 (L=1, READ_FIRST, no clear) and dut1 (L=2, WRITE_FIRST, clear) share stimulus.
module tb_blram_dp;
    import blram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [3:0]  a_we = '0, b_we = '0;
    logic [13:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;
    logic        busy0, busy1, err0, err1;

    int nchk = 0;
    int nerr = 0;

    blram_dp_if #(.ADDR_W(14), .DATA_W(32)) ia0 ();
    blram_dp_if #(.ADDR_W(14), .DATA_W(32)) ib0 ();
    blram_dp_if #(.ADDR_W(14), .DATA_W(32)) ia1 ();
    blram_dp_if #(.ADDR_W(14), .DATA_W(32)) ib1 ();

    assign ia0.en = a_en;  assign ia0.we = a_we;  assign ia0.addr = a_addr;  assign ia0.din = a_din;
    assign ia1.en = a_en;  assign ia1.we = a_we;  assign ia1.addr = a_addr;  assign ia1.din = a_din;
    assign ib0.en = b_en;  assign ib0.we = b_we;  assign ib0.addr = b_addr;  assign ib0.din = b_din;
    assign ib1.en = b_en;  assign ib1.we = b_we;  assign ib1.addr = b_addr;  assign ib1.din = b_din;

    blram_dp #(.ADDR_W(14), .DEPTH(1024), .DATA_W(32), .OUT_REG(0),
               .RDW_MODE(READ_FIRST), .CLEAR_ON_RESET(0)) dut0 (
        .clk(clk), .rst(rst), .a_if(ia0), .b_if(ib0), .busy(busy0), .err(err0));

    blram_dp #(.ADDR_W(14), .DEPTH(1024), .DATA_W(32), .OUT_REG(1),
               .RDW_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .a_if(ia1), .b_if(ib1), .busy(busy1), .err(err1));

    always #5 clk = ~clk;

    typedef struct {
        logic        a_en;  logic [3:0] a_we;  logic [13:0] a_addr;  logic [31:0] a_din;
        logic        b_en;  logic [3:0] b_we;  logic [13:0] b_addr;  logic [31:0] b_din;
        logic [1:0]  a_chk; logic [31:0] a_exp0; logic [31:0] a_exp1;  // chk bit0=dut0, bit1=dut1
        logic [1:0]  b_chk; logic [31:0] b_exp0; logic [31:0] b_exp1;
        logic        err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
    endtask

    // One access cycle, then check dut0 one edge later and dut1 two edges later
    task automatic run_vec(input vec_t v, input int id);
        @(negedge clk);
        a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
        b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
        @(posedge clk); #1;
        chk($sformatf("v%0d a_vld0", id), 32'(ia0.vld), 32'(v.a_en));
        if (v.a_chk[0]) chk($sformatf("v%0d a_dout0", id), ia0.dout, v.a_exp0);
        chk($sformatf("v%0d b_vld0", id), 32'(ib0.vld), 32'(v.b_en));
        if (v.b_chk[0]) chk($sformatf("v%0d b_dout0", id), ib0.dout, v.b_exp0);
        chk($sformatf("v%0d err0", id), 32'(err0), 32'(v.err));
        chk($sformatf("v%0d early vld1", id), 32'({ia1.vld, ib1.vld, err1}), 32'd0);
        idle();
        @(posedge clk); #1;
        chk($sformatf("v%0d late vld0", id), 32'({ia0.vld, ib0.vld, err0}), 32'd0);
        if (v.a_chk[0]) chk($sformatf("v%0d a_dout0 hold", id), ia0.dout, v.a_exp0);
        chk($sformatf("v%0d a_vld1", id), 32'(ia1.vld), 32'(v.a_en));
        if (v.a_chk[1]) chk($sformatf("v%0d a_dout1", id), ia1.dout, v.a_exp1);
        chk($sformatf("v%0d b_vld1", id), 32'(ib1.vld), 32'(v.b_en));
        if (v.b_chk[1]) chk($sformatf("v%0d b_dout1", id), ib1.dout, v.b_exp1);
        chk($sformatf("v%0d err1", id), 32'(err1), 32'(v.err));
    endtask

    // Count dut1 busy cycles from the first edge after reset release; note any output activity
    task automatic measure_busy(output int n, output logic seen);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (ia1.vld || ib1.vld || err1) seen = 1'b1;
            if (!busy1) break;
            n++;
        end
        idle();
        repeat (3) begin
            @(posedge clk); #1;
            if (ia1.vld || ib1.vld || err1) seen = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int   n;
        int   cnt;
        logic seen;
        vec_t v;

        vecs[0]  = '{1'b1,4'hF,14'd0,32'h20114045,   1'b0,4'h0,14'd0,32'h0,         2'b10,32'h0,32'h20114045,       2'b00,32'h0,32'h0,                 1'b0};
        vecs[1]  = '{1'b1,4'h0,14'd0,32'h0,          1'b0,4'h0,14'd0,32'h0,         2'b11,32'h20114045,32'h20114045, 2'b00,32'h0,32'h0,                 1'b0};
        vecs[2]  = '{1'b1,4'hF,14'd5,32'h11223344,   1'b0,4'h0,14'd0,32'h0,         2'b10,32'h0,32'h11223344,       2'b00,32'h0,32'h0,                 1'b0};
        vecs[3]  = '{1'b1,4'h5,14'd5,32'hAABBCCDD,   1'b0,4'h0,14'd0,32'h0,         2'b11,32'h11223344,32'h11BB33DD, 2'b00,32'h0,32'h0,                 1'b0};
        vecs[4]  = '{1'b0,4'h0,14'd0,32'h0,          1'b1,4'h0,14'd5,32'h0,         2'b00,32'h0,32'h0,               2'b11,32'h11BB33DD,32'h11BB33DD,   1'b0};
        vecs[5]  = '{1'b1,4'hF,14'd9,32'h1,          1'b0,4'h0,14'd0,32'h0,         2'b10,32'h0,32'h1,               2'b00,32'h0,32'h0,                 1'b0};
        vecs[6]  = '{1'b1,4'hF,14'd9,32'h7,          1'b1,4'h0,14'd9,32'h0,         2'b11,32'h1,32'h7,               2'b11,32'h1,32'h1,                 1'b0};
        vecs[7]  = '{1'b0,4'h0,14'd0,32'h0,          1'b1,4'h0,14'd9,32'h0,         2'b00,32'h0,32'h0,               2'b11,32'h7,32'h7,                 1'b0};
        vecs[8]  = '{1'b1,4'hF,14'd3,32'h0,          1'b0,4'h0,14'd0,32'h0,         2'b10,32'h0,32'h0,               2'b00,32'h0,32'h0,                 1'b0};
        vecs[9]  = '{1'b1,4'h1,14'd3,32'h000000FF,   1'b1,4'hF,14'd3,32'hFFFFFF00,  2'b11,32'h0,32'h000000FF,       2'b11,32'h0,32'hFFFFFF00,         1'b1};
        vecs[10] = '{1'b1,4'h0,14'd3,32'h0,          1'b0,4'h0,14'd0,32'h0,         2'b11,32'hFFFFFFFF,32'hFFFFFFFF, 2'b00,32'h0,32'h0,                 1'b0};
        vecs[11] = '{1'b1,4'hF,14'd476,32'hCAFEF00D, 1'b0,4'h0,14'd0,32'h0,         2'b10,32'h0,32'hCAFEF00D,       2'b00,32'h0,32'h0,                 1'b0};
        vecs[12] = '{1'b1,4'hF,14'd1500,32'h12345678,1'b0,4'h0,14'd0,32'h0,         2'b11,32'h0,32'h0,               2'b00,32'h0,32'h0,                 1'b1};
        vecs[13] = '{1'b1,4'h0,14'd1500,32'h0,       1'b1,4'h0,14'd476,32'h0,       2'b11,32'h0,32'h0,               2'b11,32'hCAFEF00D,32'hCAFEF00D,   1'b1};
        vecs[14] = '{1'b1,4'h0,14'd0,32'h0,          1'b1,4'h0,14'd16383,32'h0,     2'b11,32'h20114045,32'h20114045, 2'b11,32'h0,32'h0,                 1'b1};
        vecs[15] = '{1'b1,4'hF,14'd10,32'h0000AAAA,  1'b1,4'hF,14'd11,32'h0000BBBB, 2'b10,32'h0,32'h0000AAAA,       2'b10,32'h0,32'h0000BBBB,         1'b0};
        vecs[16] = '{1'b1,4'h0,14'd11,32'h0,         1'b1,4'h0,14'd10,32'h0,        2'b11,32'h0000BBBB,32'h0000BBBB, 2'b11,32'h0000AAAA,32'h0000AAAA,   1'b0};
        vecs[17] = '{1'b1,4'h0,14'd9,32'h0,          1'b1,4'hF,14'd9,32'h55,        2'b11,32'h7,32'h7,               2'b11,32'h7,32'h55,                1'b0};
        vecs[18] = '{1'b1,4'h0,14'd9,32'h0,          1'b1,4'h0,14'd3,32'h0,         2'b11,32'h55,32'h55,             2'b11,32'hFFFFFFFF,32'hFFFFFFFF,   1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst a_dout0", ia0.dout, 32'h0);  chk("rst b_dout0", ib0.dout, 32'h0);
        chk("rst a_dout1", ia1.dout, 32'h0);  chk("rst b_dout1", ib1.dout, 32'h0);
        chk("rst vld0", 32'({ia0.vld, ib0.vld}), 32'd0);
        chk("rst vld1", 32'({ia1.vld, ib1.vld}), 32'd0);
        chk("rst err0", 32'(err0), 32'd0);    chk("rst err1", 32'(err1), 32'd0);
        chk("rst busy0", 32'(busy0), 32'd1);  chk("rst busy1", 32'(busy1), 32'd1);

        // Release reset with accesses offered throughout the fill
        @(negedge clk);
        a_en = 1'b1; a_we = '0; a_addr = 14'd1500;
        b_en = 1'b1; b_we = 4'hF; b_addr = 14'd101; b_din = 32'h9;
        rst = 1'b0;
        measure_busy(n, seen);
        chk("clear length", 32'(n), 32'd1024);
        chk("activity while busy", 32'(seen), 32'd0);
        chk("busy0 after reset", 32'(busy0), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Back-to-back reads on A: pipelining without bubbles
        @(negedge clk);
        a_en = 1'b1; a_we = '0; a_addr = 14'd0;
        @(posedge clk); #1;
        a_addr = 14'd5;
        chk("bb a_dout0 #1", ia0.dout, 32'h20114045);
        chk("bb a_vld1 #1", 32'(ia1.vld), 32'd0);
        @(posedge clk); #1;
        idle();
        chk("bb a_dout0 #2", ia0.dout, 32'h11BB33DD);
        chk("bb a_vld1 #2", 32'(ia1.vld), 32'd1);
        chk("bb a_dout1 #2", ia1.dout, 32'h20114045);
        @(posedge clk); #1;
        chk("bb a_vld0 #3", 32'(ia0.vld), 32'd0);
        chk("bb a_vld1 #3", 32'(ia1.vld), 32'd1);
        chk("bb a_dout1 #3", ia1.dout, 32'h11BB33DD);
        @(posedge clk); #1;
        chk("bb a_vld1 #4", 32'(ia1.vld), 32'd0);
        chk("bb a_dout1 hold", ia1.dout, 32'h11BB33DD);

        // Preload word 101 with 6 on both instances
        v = '{1'b1,4'hF,14'd101,32'h6, 1'b0,4'h0,14'd0,32'h0, 2'b10,32'h0,32'h6, 2'b00,32'h0,32'h0, 1'b0};
        run_vec(v, 100);
        v = '{1'b1,4'h0,14'd101,32'h0, 1'b0,4'h0,14'd0,32'h0, 2'b11,32'h6,32'h6, 2'b00,32'h0,32'h0, 1'b0};
        run_vec(v, 101);

        // Reset, let the fill reach 500 words, reset again: fill must restart in full
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 500; i++) begin
            @(posedge clk); #1;
            if (busy1) cnt++;
        end
        chk("fill reached 500", 32'(cnt), 32'd500);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        measure_busy(n, seen);
        chk("restarted clear length", 32'(n), 32'd1024);
        chk("restart activity", 32'(seen), 32'd0);

        // dut1 zero-filled word 101; dut0 keeps it across reset
        v = '{1'b1,4'h0,14'd101,32'h0, 1'b0,4'h0,14'd0,32'h0, 2'b11,32'h6,32'h0, 2'b00,32'h0,32'h0, 1'b0};
        run_vec(v, 102);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/blram_dp.md
# blram_dp

Parametrised true dual-port block RAM, the successor to the single-port `blram` used next to `VerySimpleCPU`. It has two independent ports: port A for the CPU and port B for a loader, DMA or debug master. Each port has per-byte write enables, a read strobe with a valid flag, selectable read latency and selectable read-during-write behaviour. An optional post-reset clear engine zero-fills the array before the ports are opened.

## Interface
Parameters:
- `ADDR_W`, 14: address width of both ports.
- `DEPTH`, 1024: number of words. Must satisfy DEPTH ≤ 2^ADDR_W.
- `DATA_W`, 32: word width. Must be a multiple of 8.
- `OUT_REG`, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- `RDW_MODE`, READ_FIRST: same-port read-during-write. READ_FIRST returns old data; WRITE_FIRST returns merged new data.
- `CLEAR_ON_RESET`, 0: 1 enables the zero-fill engine after reset.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `a_en` in 1: port A access strobe.
- `a_we` in DATA_W/8: port A byte write enables. Only meaningful when `a_en`=1.
- `a_addr` in ADDR_W: port A word address.
- `a_din` in DATA_W: port A write data.
- `a_dout` out DATA_W: port A read data.
- `a_vld` out 1: 1-cycle pulse when `a_dout` carries the result of an accepted read.
- `b_en`, `b_we`, `b_addr`, `b_din`, `b_dout`, `b_vld`: port B, identical to port A.
- `busy` out 1: clear engine active. Port accesses are refused while it is high.
- `err` out 1: 1-cycle pulse on an out-of-range access or a write-write collision.

## Operation
- An access is accepted when `x_en`=1, `busy`=0 and `rst`=0.
- A read is any accepted access. If `x_we`≠0, the access is also a write, applied byte-wise: byte i is written iff `x_we[i]`.
- An accepted access with `x_we`=0 is a pure read. Every accepted access produces `x_vld`.
- `x_dout` holds its last value when no read completes.
- Out-of-range addresses (`addr` ≥ DEPTH):
  - The write is dropped.
  - The read returns 0 with `x_vld` asserted.
  - `err` pulses.
  - Addresses are never wrapped modulo DEPTH.
- Same-port read-during-write follows `RDW_MODE`. For WRITE_FIRST, unwritten bytes return their old value.
- Cross-port interaction at the same address in the same cycle:
  - Port A write and port B read: B returns the old word, regardless of `RDW_MODE`. The same holds with the ports swapped.
  - Both ports write: bytes enabled on A take A's data, bytes enabled only on B take B's data, and `err` pulses.
- Clear engine FSM, states IDLE, CLEAR, READY:
  - `rst` forces IDLE and sets the address counter to 0.
  - On the first cycle with `rst`=0: go to CLEAR if CLEAR_ON_RESET=1, otherwise go to READY.
  - CLEAR writes 0 to address `cnt` each cycle and increments `cnt`. After writing DEPTH−1 it goes to READY. CLEAR therefore lasts exactly DEPTH cycles.
  - `busy` is 1 in IDLE and CLEAR, and 0 in READY.
- Accesses offered while `busy`=1 are ignored: no write, no `x_vld`, no `err`.
- Reset in the middle of CLEAR aborts the fill. Clearing restarts from address 0 after reset is released.
- Reset does not alter array contents. Preloaded initial contents survive when CLEAR_ON_RESET=0.

## Timing
- Reset values: `a_dout`=`b_dout`=0, `a_vld`=`b_vld`=0, `err`=0, `busy`=1. The output register and valid pipeline are cleared.
- Read latency L = 1 + OUT_REG, measured from the accepting edge to the edge where `x_dout`/`x_vld` update.
- One accepted access per port per cycle, fully pipelined, with no back-pressure.
- Writes are visible to a read accepted on the next edge. The same-edge case follows the RDW and cross-port rules above.
- `err` is asserted L cycles after the offending edge, aligned with the corresponding `x_vld`.
- `busy` falls on the edge after the final clear write. The first access can be accepted in that same cycle.

## Structure
- Package `blram_pkg`:
  - `rdw_mode_t` enum {READ_FIRST, WRITE_FIRST}.
  - `clr_state_t` enum {IDLE, CLEAR, READY}.
  - Helper function for the byte-merge.
- Sub-module `blram_port`, instantiated twice. It contains:
  - per-port accept logic;
  - range check;
  - the RDW mux;
  - the L-stage `dout`/`vld` pipeline.
- The top level holds the array, cross-port collision resolution and the clear FSM.

## Test plan
- Latency and valid: OUT_REG=0 and 1. Write 32'h20114045 to addr 0 on A, then read addr 0 on A. Required: `a_vld` and `a_dout`=32'h20114045 appear exactly L edges after the read.
- Byte enables: word 5 is 32'h11223344. Write A `a_we`=4'b0101, `a_din`=32'hAABBCCDD. A subsequent read returns 32'h11BB33DD.
- RDW and cross-port:
  - Word 9 holds 1. In one cycle, A writes 7 to addr 9 while B reads addr 9. B returns 1.
  - Repeat with the same-port read/write on A under WRITE_FIRST. A returns 7.
- Collision: word 3 holds 0. In the same cycle, A writes 32'h000000FF (we=4'b0001) and B writes 32'hFFFFFF00 (we=4'b1111) to addr 3. Required: `err` pulses once, and a later read returns 32'hFFFFFFFF.
- Out of range: DEPTH=1024. Write to addr 1500, then read addr 1500. Required: `err` pulses, `a_dout`=0 with `a_vld` asserted, and memory is unchanged.
- Clear engine: CLEAR_ON_RESET=1, word 101 preloaded with 6.
  - Release reset. `busy` is high for exactly 1024 cycles, and access attempts during that window produce no `vld`.
  - Afterwards, word 101 reads 0.
  - Asserting `rst` at count 500 restarts the fill, and it again lasts the full 1024 cycles.
